pwm_multi_channel_core: RTL and testbench

//  Parametrised successor to the fixed 16-output PWM peripheral. NUM_CH channels share one

---
 rtl/pwm_multi_channel_core_if.sv | 10 +
 rtl/pwm_multi_channel_core.sv | 78 +++++++
 tb/tb_pwm_multi_channel_core.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pwm_multi_channel_core_if.sv
// pwm_multi_channel_core_if: byte-wide register write/read port between the SPI peripheral and the PWM core
interface pwm_multi_channel_core_if;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
  modport slave (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/pwm_multi_channel_core.sv
// pwm_multi_channel_core: NUM_CH PWM channels on one prescaled period counter with double-buffered duties
module pwm_multi_channel_core #(
  parameter int NUM_CH      = 16,
  parameter int PRESCALE_W  = 12,
  parameter int DEFAULT_DIV = 3299
) (
  input  logic                     clk,
  input  logic                     rst,
  pwm_multi_channel_core_if.slave  bus,
  output logic [NUM_CH-1:0]        out
);
  logic [NUM_CH-1:0]     r_en_out, r_en_pwm, r_out, w_raw;
  logic                  r_run, r_inv;
  logic [PRESCALE_W-1:0] r_div, r_pre;
  logic [7:0]            r_top, r_cnt, r_rd_data, w_rd;
  logic [7:0]            r_duty   [NUM_CH];
  logic [7:0]            r_shadow [NUM_CH];
  logic [31:0]           w_en_out32, w_en_pwm32;
  logic [15:0]           w_div16;
  logic                  w_tick, w_wrap;
  // pre >= div rather than == so a divisor written below pre wraps on the next cycle
  assign w_tick     = r_pre >= r_div;
  assign w_wrap     = r_run && w_tick && r_cnt >= r_top;
  assign w_en_out32 = 32'(r_en_out);
  assign w_en_pwm32 = 32'(r_en_pwm);
  assign w_div16    = 16'(r_div);
  assign bus.rd_data = r_rd_data;
  assign out         = r_out;
  always_comb begin
    w_raw = '0;
    for (int c = 0; c < NUM_CH; c++) w_raw[c] = r_run && (r_cnt < r_shadow[c]);
  end
  always_comb begin
    w_rd = 8'h00;
    if (bus.rd_addr < 6'h04) w_rd = w_en_out32[{bus.rd_addr[1:0], 3'b000} +: 8];
    else if (bus.rd_addr < 6'h08) w_rd = w_en_pwm32[{bus.rd_addr[1:0], 3'b000} +: 8];
    else if (bus.rd_addr == 6'h08) w_rd = {6'b0, r_inv, r_run};
    else if (bus.rd_addr == 6'h09) w_rd = w_div16[7:0];
    else if (bus.rd_addr == 6'h0A) w_rd = w_div16[15:8];
    else if (bus.rd_addr == 6'h0B) w_rd = r_top;
    for (int c = 0; c < NUM_CH; c++) if (bus.rd_addr == 6'(16 + c)) w_rd = r_duty[c];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_out  <= '0;
      r_en_pwm  <= '0;
      r_run     <= 1'b1;
      r_inv     <= 1'b0;
      r_div     <= PRESCALE_W'(DEFAULT_DIV);
      r_top     <= 8'hFF;
      r_pre     <= '0;
      r_cnt     <= '0;
      r_out     <= '0;
      r_rd_data <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_duty[c]   <= '0;
        r_shadow[c] <= '0;
      end
    end else begin
      r_pre     <= (!r_run || w_tick) ? '0 : r_pre + PRESCALE_W'(1);
      r_cnt     <= (!r_run || w_wrap) ? '0 : r_cnt + 8'(w_tick);
      r_out     <= r_en_out & (~r_en_pwm | (w_raw ^ {NUM_CH{r_inv}}));
      r_rd_data <= w_rd;
      for (int c = 0; c < NUM_CH; c++) if (!r_run || w_wrap) r_shadow[c] <= r_duty[c];
      if (bus.wr_en) begin
        if (bus.wr_addr == 6'h08) {r_inv, r_run} <= bus.wr_data[1:0];
        if (bus.wr_addr == 6'h0B) r_top <= bus.wr_data;
        for (int j = 0; j < NUM_CH; j++) begin
          if (bus.wr_addr == 6'(j / 8)) r_en_out[j] <= bus.wr_data[3'(j % 8)];
          if (bus.wr_addr == 6'(4 + j / 8)) r_en_pwm[j] <= bus.wr_data[3'(j % 8)];
          if (bus.wr_addr == 6'(16 + j)) r_duty[j] <= bus.wr_data;
        end
        for (int j = 0; j < PRESCALE_W; j++)
          if (bus.wr_addr == (j < 8 ? 6'h09 : 6'h0A)) r_div[j] <= bus.wr_data[3'(j % 8)];
      end
    end
  end
endmodule

// File: tb/tb_pwm_multi_channel_core.sv
// tb_pwm_multi_channel_core: scoreboard bench for register map, PWM waveforms, double buffering and reset
module tb_pwm_multi_channel_core;
  localparam int NUM_CH = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_CH-1:0] out;
  int n_run = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  string tag_q[$];
  pwm_multi_channel_core_if bus();
  pwm_multi_channel_core #(.NUM_CH(NUM_CH), .PRESCALE_W(12), .DEFAULT_DIV(3299)) dut (
    .clk(clk), .rst(rst), .bus(bus), .out(out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask
  task automatic push(input string tag, input logic [31:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask
  task automatic pop_chk(input logic [31:0] act);
    if (exp_q.size() == 0) check("sb_underflow", 32'd0, 32'd1);
    else check(tag_q.pop_front(), act, exp_q.pop_front());
  endtask
  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
  endtask
  task automatic rd(input logic [5:0] a, input logic [7:0] e);
    bus.rd_addr = a;
    push($sformatf("rd_%02h", a), 32'(e));
    @(posedge clk);
    #1 pop_chk(32'(bus.rd_data));
  endtask
  // expected out[0] follows pat LSB-first with period len; every other channel stays low
  task automatic outs(input string tag, input logic [31:0] pat, input int len, input int n);
    for (int i = 0; i < n; i++) push($sformatf("%s_%0d", tag, i), 32'(pat[i % len]));
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 pop_chk(32'(out));
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("out_reset", 32'(out), 32'd0);
    for (int a = 0; a < 12; a++)
      rd(6'(a), a == 8 ? 8'h01 : a == 9 ? 8'hE3 : a == 10 ? 8'h0C : a == 11 ? 8'hFF : 8'h00);
    for (int a = 16; a < 16 + NUM_CH; a++) rd(6'(a), 8'h00);
    rd(6'h0C, 8'h00);
    wr(6'h00, 8'h01);
    check("out_static_lag", 32'(out), 32'd0);
    outs("static", 32'b1, 1, 3);
    wr(6'h08, 8'h03);
    outs("static_inv", 32'b1, 1, 4);
    wr(6'h08, 8'h00);
    wr(6'h09, 8'h00);
    wr(6'h0A, 8'h00);
    wr(6'h0B, 8'h03);
    wr(6'h10, 8'h02);
    wr(6'h04, 8'h01);
    wr(6'h08, 8'h01);
    outs("pwm_d2", 32'b0011, 4, 12);
    wr(6'h08, 8'h02);
    wr(6'h08, 8'h03);
    outs("pwm_d2_inv", 32'b1100, 4, 12);
    wr(6'h08, 8'h00);
    wr(6'h08, 8'h01);
    wr(6'h10, 8'h04);
    outs("dbuf", 32'b1111_1001, 8, 8);
    outs("dbuf_high", 32'b1, 1, 4);
    wr(6'h08, 8'h00);
    wr(6'h09, 8'h02);
    wr(6'h0B, 8'h01);
    wr(6'h10, 8'h01);
    wr(6'h08, 8'h01);
    outs("div2", 32'b000111, 6, 12);
    wr(6'h08, 8'h00);
    outs("stopped", 32'b0, 1, 5);
    wr(6'h08, 8'h01);
    outs("restart", 32'b000111, 6, 12);
    wr(6'h00, 8'hFF);
    rst = 1'b1;
    @(posedge clk);
    #1 check("out_midrst", 32'(out), 32'd0);
    rst = 1'b0;
    rd(6'h00, 8'h00);
    rd(6'h04, 8'h00);
    rd(6'h08, 8'h01);
    rd(6'h09, 8'hE3);
    rd(6'h0A, 8'h0C);
    rd(6'h0B, 8'hFF);
    rd(6'h10, 8'h00);
    wr(6'h3F, 8'hAA);
    rd(6'h3F, 8'h00);
    wr(6'h02, 8'hFF);
    rd(6'h02, 8'h00);
    wr(6'h01, 8'hA5);
    rd(6'h01, 8'hA5);
    wr(6'h0A, 8'hFF);
    rd(6'h0A, 8'h0F);
    wr(6'h08, 8'hFF);
    rd(6'h08, 8'h03);
    bus.rd_addr = 6'h0B;
    push("rd_same_cycle", 32'hFF);
    push("rd_after_write", 32'h55);
    wr(6'h0B, 8'h55);
    pop_chk(32'(bus.rd_data));
    @(posedge clk);
    #1 pop_chk(32'(bus.rd_data));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
